// File: rtl/cvp14_pkg.sv
// Purpose: shared constants and types for the CVP14 vector load/store sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: vld/vst opcodes, default geometry, Op encoding, FSM state encoding,
// and an index-width helper used by the address generator.
package cvp14_pkg;

  // Decoder opcodes that map onto this block's Op input.
  localparam logic [3:0] OPC_VLD = 4'b0100;
  localparam logic [3:0] OPC_VST = 4'b0101;

  // Default vector geometry.
  localparam int unsigned ELEMS_DEF = 16;
  localparam int unsigned DW_DEF    = 16;
  localparam int unsigned AW_DEF    = 16;

  // Op input encoding.
  localparam logic OP_LOAD  = 1'b0;
  localparam logic OP_STORE = 1'b1;

  // Sequencer states. The op is carried by which of LOAD/STORE is active,
  // so no separate op register is kept after accept.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_LTAIL = 3'd2,
    ST_STORE = 3'd3,
    ST_DONE  = 3'd4
  } seq_state_t;

  // Width of an element index; at least one bit so a 1-element build still elaborates.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vec_addr_gen.sv
// Purpose: per-element memory address generator for the vector sequencer.
// Latency: address for element 0 is registered on accept; each advance steps one element.
// Backpressure: none; advances only when the sequencer asserts i_adv.
//
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_accept          command accepted: latch i_base / i_stride, clear the index
//   i_adv             step to the next element
//   i_base, i_stride  element-0 address and per-element stride
//   o_addr            registered address of the current element
//   o_last            current element is the final one (index ELEMS-1)
module vec_addr_gen
  import cvp14_pkg::*;
#(
  parameter int unsigned ELEMS = ELEMS_DEF,
  parameter int unsigned AW    = AW_DEF
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_accept,
  input  logic          i_adv,
  input  logic [AW-1:0] i_base,
  input  logic [AW-1:0] i_stride,
  output logic [AW-1:0] o_addr,
  output logic          o_last
);

  localparam int unsigned IW = idx_width(ELEMS);

  logic [AW-1:0] r_addr;
  logic [AW-1:0] r_stride;
  logic [IW-1:0] r_idx;

  // Addresses are accumulated rather than multiplied: base + k*stride is reached by
  // adding the stride once per element. The AW-bit adder drops the carry, which is
  // exactly the modulo-2^AW wrap wanted at the top of memory.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_addr   <= '0;
      r_stride <= '0;
      r_idx    <= '0;
    end else if (i_accept) begin
      r_addr   <= i_base;
      r_stride <= i_stride;
      r_idx    <= '0;
    end else if (i_adv) begin
      r_addr   <= r_addr + r_stride;
      r_idx    <= r_idx + IW'(1);
    end
  end

  assign o_addr = r_addr;
  assign o_last = (r_idx == IW'(ELEMS - 1));

endmodule

// File: rtl/vec_mem_seq.sv
// Purpose: vector load/store sequencer moving ELEMS words between data memory and one vector register.
// Latency: load -> Done/VecWR 17 cycles after accept; store -> Done 16 cycles after accept.
// Backpressure: none; Start is only sampled in IDLE, a Start while Busy is dropped (not queued).
//
// Optional feature macro: STRIDE_EN (adds the Stride input; otherwise stride is fixed at 1).
//
// Ports:
//   Clk1, Reset        clock, synchronous active-high reset
//   Start, Op          command valid (IDLE only), 0 = load, 1 = store
//   BaseAddr           element-0 address
//   Stride             (STRIDE_EN only) per-element address step, latched at accept
//   VecIn              store source, element i at [DW*i +: DW], snapshotted at accept
//   VecOut, VecWR      load result and its one-cycle register-write strobe
//   Busy, Done         command in progress, one-cycle completion pulse
//   MemAddr, MemRD     memory address and read request (data returns next cycle)
//   MemWR, MemDataOut  memory write strobe and write data
//   MemDataIn          read data, valid the cycle after MemRD
module vec_mem_seq
  import cvp14_pkg::*;
#(
  parameter int unsigned ELEMS = ELEMS_DEF,
  parameter int unsigned DW    = DW_DEF,
  parameter int unsigned AW    = AW_DEF
) (
  input  logic                Clk1,
  input  logic                Reset,
  input  logic                Start,
  input  logic                Op,
  input  logic [AW-1:0]       BaseAddr,
`ifdef STRIDE_EN
  input  logic [AW-1:0]       Stride,
`endif
  input  logic [ELEMS*DW-1:0] VecIn,
  output logic [ELEMS*DW-1:0] VecOut,
  output logic                VecWR,
  output logic                Busy,
  output logic                Done,
  output logic [AW-1:0]       MemAddr,
  output logic                MemRD,
  output logic                MemWR,
  output logic [DW-1:0]       MemDataOut,
  input  logic [DW-1:0]       MemDataIn
);

  localparam int unsigned VW = ELEMS * DW;

  seq_state_t      r_state;
  logic            r_busy;
  logic            r_done;
  logic            r_vec_wr;
  logic            r_mem_rd;
  logic            r_mem_wr;
  logic [DW-1:0]   r_mem_dout;
  logic [VW-1:0]   r_vec_out;
  logic [VW-1:0]   r_buf;       // load assembly buffer, kept apart so VecOut holds until completion
  logic [VW-1:0]   r_snap;      // store snapshot, shifted down one element per write
  logic            r_cap_vld;   // MemDataIn carries read data this cycle

  logic            w_accept;
  logic            w_adv;
  logic            w_last;
  logic [AW-1:0]   w_stride;
  logic [AW-1:0]   w_addr;
  logic [VW-1:0]   w_buf_shift;

`ifdef STRIDE_EN
  assign w_stride = Stride;
`else
  assign w_stride = AW'(1);
`endif

  assign w_accept = (r_state == ST_IDLE) && Start;
  // Step the address while issuing, except on the final element so MemAddr holds it.
  assign w_adv    = ((r_state == ST_LOAD) || (r_state == ST_STORE)) && !w_last;

  // Read data enters at the top and shifts down; after ELEMS captures, element 0
  // (the first word returned) sits in the lowest slot, matching VecIn packing.
  assign w_buf_shift = {MemDataIn, r_buf[VW-1:DW]};

  vec_addr_gen #(
    .ELEMS (ELEMS),
    .AW    (AW)
  ) u_addr_gen (
    .i_clk    (Clk1),
    .i_rst    (Reset),
    .i_accept (w_accept),
    .i_adv    (w_adv),
    .i_base   (BaseAddr),
    .i_stride (w_stride),
    .o_addr   (w_addr),
    .o_last   (w_last)
  );

  always_ff @(posedge Clk1) begin
    if (Reset) begin
      r_state    <= ST_IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_vec_wr   <= 1'b0;
      r_mem_rd   <= 1'b0;
      r_mem_wr   <= 1'b0;
      r_mem_dout <= '0;
      r_vec_out  <= '0;
      r_buf      <= '0;
      r_snap     <= '0;
      r_cap_vld  <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_vec_wr  <= 1'b0;
      // A read issued this cycle returns data next cycle; capture one edge later.
      r_cap_vld <= r_mem_rd;
      if (r_cap_vld) begin
        r_buf <= w_buf_shift;
      end

      case (r_state)
        ST_IDLE: begin
          if (Start) begin
            r_busy <= 1'b1;
            if (Op == OP_STORE) begin
              r_state    <= ST_STORE;
              r_mem_wr   <= 1'b1;
              r_mem_dout <= VecIn[DW-1:0];
              r_snap     <= VecIn >> DW;
            end else begin
              r_state  <= ST_LOAD;
              r_mem_rd <= 1'b1;
            end
          end
        end

        ST_LOAD: begin
          if (w_last) begin
            r_state  <= ST_LTAIL;
            r_mem_rd <= 1'b0;
          end
        end

        // Waiting for the final element's read data; the completed vector is
        // published straight from the shift path so VecOut is whole with VecWR.
        ST_LTAIL: begin
          if (r_cap_vld) begin
            r_state   <= ST_DONE;
            r_done    <= 1'b1;
            r_vec_wr  <= 1'b1;
            r_vec_out <= w_buf_shift;
          end
        end

        ST_STORE: begin
          if (w_last) begin
            r_state  <= ST_DONE;
            r_mem_wr <= 1'b0;
            r_done   <= 1'b1;
          end else begin
            r_mem_dout <= r_snap[DW-1:0];
            r_snap     <= r_snap >> DW;
          end
        end

        // Busy stays high through the Done cycle so a Start here is ignored.
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end

        default: begin
          r_state  <= ST_IDLE;
          r_busy   <= 1'b0;
          r_mem_rd <= 1'b0;
          r_mem_wr <= 1'b0;
        end
      endcase
    end
  end

  assign VecOut     = r_vec_out;
  assign VecWR      = r_vec_wr;
  assign Busy       = r_busy;
  assign Done       = r_done;
  assign MemAddr    = w_addr;
  assign MemRD      = r_mem_rd;
  assign MemWR      = r_mem_wr;
  assign MemDataOut = r_mem_dout;

endmodule

// File: tb/tb_vec_mem_seq.sv
// Purpose: directed self-checking bench for vec_mem_seq (loads, stores, wrap, ignored Start, reset abort).
// Latency: checks the 16/17-cycle command timing edge by edge.
// Backpressure: Start held high through Busy to show it is dropped, not queued.
module tb_vec_mem_seq;

  logic          Clk1 = 1'b0;
  logic          Reset;
  logic          Start;
  logic          Op;
  logic [15:0]   BaseAddr;
`ifdef STRIDE_EN
  logic [15:0]   Stride;
`endif
  logic [255:0]  VecIn;
  logic [255:0]  VecOut;
  logic          VecWR;
  logic          Busy;
  logic          Done;
  logic [15:0]   MemAddr;
  logic          MemRD;
  logic          MemWR;
  logic [15:0]   MemDataOut;
  logic [15:0]   MemDataIn;

  int errors = 0;
  int checks = 0;

  always #5 Clk1 = ~Clk1;

  vec_mem_seq dut (
    .Clk1       (Clk1),
    .Reset      (Reset),
    .Start      (Start),
    .Op         (Op),
    .BaseAddr   (BaseAddr),
`ifdef STRIDE_EN
    .Stride     (Stride),
`endif
    .VecIn      (VecIn),
    .VecOut     (VecOut),
    .VecWR      (VecWR),
    .Busy       (Busy),
    .Done       (Done),
    .MemAddr    (MemAddr),
    .MemRD      (MemRD),
    .MemWR      (MemWR),
    .MemDataOut (MemDataOut),
    .MemDataIn  (MemDataIn)
  );

  // Read image (preloaded by the initial block) and a separate write image.
  logic [15:0] mem    [0:65535];
  logic [15:0] st_mem [0:65535];

  always @(posedge Clk1) begin
    if (MemWR) st_mem[MemAddr] <= MemDataOut;
    if (MemRD) MemDataIn <= mem[MemAddr];
  end

  task automatic test_reset;
    Reset = 1'b1; Start = 1'b0; Op = 1'b0; BaseAddr = 16'h0000; VecIn = '0;
    repeat (2) @(negedge Clk1);
    checks++;
    if ({VecWR, Busy, Done, MemRD, MemWR, MemAddr, MemDataOut} !== 37'd0)
      $display("FAIL reset_ctl got %h want 0", {VecWR, Busy, Done, MemRD, MemWR, MemAddr, MemDataOut});
    if ({VecWR, Busy, Done, MemRD, MemWR, MemAddr, MemDataOut} !== 37'd0) errors++;
    checks++;
    if (VecOut !== 256'd0) begin errors++; $display("FAIL reset_vecout got %h want 0", VecOut); end
    Reset = 1'b0;
    @(negedge Clk1);
  endtask

  task automatic test_load;
    logic [255:0] exp_vec;
    logic [15:0]  ea;
    for (int i = 0; i < 16; i++) exp_vec[16*i +: 16] = 16'h1111 * i[15:0];
    Start = 1'b1; Op = 1'b0; BaseAddr = 16'h0100;
    @(negedge Clk1);
    Start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      ea = 16'h0100 + 16'(k);
      checks++;
      if ({MemRD, MemWR, Busy, Done, VecWR, MemAddr} !== {5'b10100, ea}) begin
        errors++;
        $display("FAIL load_issue k=%0d got rd=%b wr=%b busy=%b done=%b addr=%h want addr=%h",
                 k, MemRD, MemWR, Busy, Done, MemAddr, ea);
      end
      @(negedge Clk1);
    end
    checks++;
    if ({MemRD, Busy, Done, VecWR} !== 4'b0100) begin
      errors++; $display("FAIL load_tail got rd/busy/done/wr=%b want 0100", {MemRD, Busy, Done, VecWR});
    end
    @(negedge Clk1);
    checks++;
    if ({Busy, Done, VecWR} !== 3'b111) begin
      errors++; $display("FAIL load_done got busy/done/vecwr=%b want 111", {Busy, Done, VecWR});
    end
    checks++;
    if (VecOut !== exp_vec) begin errors++; $display("FAIL load_data got %h want %h", VecOut, exp_vec); end
    @(negedge Clk1);
    checks++;
    if ({Busy, Done, VecWR} !== 3'b000 || VecOut !== exp_vec) begin
      errors++; $display("FAIL load_idle got busy/done/vecwr=%b vec=%h", {Busy, Done, VecWR}, VecOut);
    end
  endtask

  task automatic test_store;
    logic [255:0] exp_vec;
    logic [15:0]  ea;
    logic [15:0]  ed;
    for (int i = 0; i < 16; i++) exp_vec[16*i +: 16] = 16'h1111 * i[15:0];
    for (int i = 0; i < 16; i++) VecIn[16*i +: 16] = 16'hA000 + 16'(i);
    Start = 1'b1; Op = 1'b1; BaseAddr = 16'h0200;
    @(negedge Clk1);
    Start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      ea = 16'h0200 + 16'(k);
      ed = 16'hA000 + 16'(k);
      checks++;
      if ({MemWR, MemRD, Busy, Done, VecWR, MemAddr, MemDataOut} !== {5'b10100, ea, ed}) begin
        errors++;
        $display("FAIL store_issue k=%0d got wr=%b rd=%b busy=%b done=%b addr=%h dat=%h want addr=%h dat=%h",
                 k, MemWR, MemRD, Busy, Done, MemAddr, MemDataOut, ea, ed);
      end
      if (k == 2) VecIn = {16{16'h5555}};
      @(negedge Clk1);
    end
    checks++;
    if ({MemWR, MemRD, Busy, Done, VecWR} !== 5'b00110) begin
      errors++; $display("FAIL store_done got wr/rd/busy/done/vecwr=%b want 00110", {MemWR, MemRD, Busy, Done, VecWR});
    end
    @(negedge Clk1);
    checks++;
    if ({Busy, Done, VecWR} !== 3'b000) begin
      errors++; $display("FAIL store_idle got busy/done/vecwr=%b want 000", {Busy, Done, VecWR});
    end
    for (int i = 0; i < 16; i++) begin
      ea = 16'h0200 + 16'(i);
      ed = 16'hA000 + 16'(i);
      checks++;
      if (st_mem[ea] !== ed) begin errors++; $display("FAIL store_mem addr=%h got %h want %h", ea, st_mem[ea], ed); end
    end
    checks++;
    if (VecOut !== exp_vec) begin errors++; $display("FAIL store_vecout_hold got %h want %h", VecOut, exp_vec); end
  endtask

  task automatic test_wrap;
    logic [255:0] exp_vec;
    logic [15:0]  ea;
    for (int i = 0; i < 16; i++) exp_vec[16*i +: 16] = 16'h3000 + 16'(i);
    Start = 1'b1; Op = 1'b0; BaseAddr = 16'hFFF8;
    @(negedge Clk1);
    Start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      ea = 16'hFFF8 + 16'(k);
      checks++;
      if ({MemRD, MemAddr} !== {1'b1, ea}) begin
        errors++; $display("FAIL wrap_addr k=%0d got rd=%b addr=%h want %h", k, MemRD, MemAddr, ea);
      end
      @(negedge Clk1);
    end
    @(negedge Clk1);
    checks++;
    if ({Done, VecWR} !== 2'b11 || VecOut !== exp_vec) begin
      errors++; $display("FAIL wrap_data got done/wr=%b vec=%h want %h", {Done, VecWR}, VecOut, exp_vec);
    end
    @(negedge Clk1);
  endtask

  task automatic test_back_to_back;
    logic [255:0] exp_vec;
    logic [15:0]  ea;
    logic [15:0]  ed;
    int dones;
    int both;
    for (int i = 0; i < 16; i++) exp_vec[16*i +: 16] = 16'h1111 * i[15:0];
    Start = 1'b1; Op = 1'b0; BaseAddr = 16'h0100;
    @(negedge Clk1);
    dones = 0; both = 0;
    // Start stays high for the whole load, including its Done cycle.
    for (int s = 0; s < 18; s++) begin
      if (s == 0) begin
        Op = 1'b1; BaseAddr = 16'h0300;
        for (int i = 0; i < 16; i++) VecIn[16*i +: 16] = 16'hB000 + 16'(i);
      end
      if (Done) dones++;
      if (MemRD && MemWR) both++;
      if (MemWR) both++;
      @(negedge Clk1);
    end
    checks++;
    if (dones !== 1 || both !== 0) begin
      errors++; $display("FAIL b2b_ignored got dones=%0d wr_seen=%0d want 1 and 0", dones, both);
    end
    checks++;
    if ({Busy, Done, MemWR, MemRD} !== 4'b0000 || VecOut !== exp_vec) begin
      errors++; $display("FAIL b2b_idle got busy/done/wr/rd=%b vec=%h", {Busy, Done, MemWR, MemRD}, VecOut);
    end
    @(negedge Clk1);
    checks++;
    if ({Busy, MemWR, MemRD, MemAddr, MemDataOut} !== {3'b110, 16'h0300, 16'hB000}) begin
      errors++; $display("FAIL b2b_accept got busy=%b wr=%b rd=%b addr=%h dat=%h want 1 1 0 0300 b000",
                         Busy, MemWR, MemRD, MemAddr, MemDataOut);
    end
    Start = 1'b0;
    dones = 0;
    for (int c = 0; c < 40; c++) begin
      if (Done) dones++;
      if (MemRD && MemWR) both++;
      @(negedge Clk1);
    end
    checks++;
    if (dones !== 1 || both !== 0 || Busy !== 1'b0) begin
      errors++; $display("FAIL b2b_store_done got dones=%0d both=%0d busy=%b want 1 0 0", dones, both, Busy);
    end
    for (int i = 0; i < 16; i += 5) begin
      ea = 16'h0300 + 16'(i);
      ed = 16'hB000 + 16'(i);
      checks++;
      if (st_mem[ea] !== ed) begin errors++; $display("FAIL b2b_mem addr=%h got %h want %h", ea, st_mem[ea], ed); end
    end
  endtask

  task automatic test_reset_mid;
    logic [255:0] exp_vec;
    int seen;
    int waited;
    for (int i = 0; i < 16; i++) exp_vec[16*i +: 16] = 16'h1111 * i[15:0];
    Start = 1'b1; Op = 1'b0; BaseAddr = 16'hFFF8;
    @(negedge Clk1);
    Start = 1'b0;
    repeat (7) @(negedge Clk1);
    checks++;
    if ({MemRD, MemAddr} !== {1'b1, 16'hFFFF}) begin
      errors++; $display("FAIL rstmid_elem7 got rd=%b addr=%h want 1 ffff", MemRD, MemAddr);
    end
    Reset = 1'b1;
    @(negedge Clk1);
    Reset = 1'b0;
    checks++;
    if ({MemRD, Busy, Done, VecWR} !== 4'b0000 || VecOut !== 256'd0) begin
      errors++; $display("FAIL rstmid_clear got rd/busy/done/wr=%b vec=%h want 0", {MemRD, Busy, Done, VecWR}, VecOut);
    end
    seen = 0;
    for (int c = 0; c < 14; c++) begin
      if (Done || VecWR || Busy) seen++;
      @(negedge Clk1);
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL rstmid_no_done got %0d active cycles want 0", seen); end
    Start = 1'b1; Op = 1'b0; BaseAddr = 16'h0100;
    @(negedge Clk1);
    Start = 1'b0;
    waited = 1;
    while (!Done && waited < 40) begin
      @(negedge Clk1);
      waited++;
    end
    checks++;
    if (waited !== 18 || VecWR !== 1'b1 || VecOut !== exp_vec) begin
      errors++; $display("FAIL rstmid_reload got cycles=%0d vecwr=%b vec=%h want 18 1 %h", waited, VecWR, VecOut, exp_vec);
    end
    @(negedge Clk1);
  endtask

`ifdef STRIDE_EN
  task automatic test_stride;
    logic [15:0] ea;
    Stride = 16'd4; Start = 1'b1; Op = 1'b0; BaseAddr = 16'h0010;
    @(negedge Clk1);
    Start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      ea = 16'h0010 + 16'(4 * k);
      checks++;
      if ({MemRD, MemAddr} !== {1'b1, ea}) begin
        errors++; $display("FAIL stride4 k=%0d got rd=%b addr=%h want %h", k, MemRD, MemAddr, ea);
      end
      @(negedge Clk1);
    end
    repeat (3) @(negedge Clk1);
    Stride = 16'd0; Start = 1'b1;
    @(negedge Clk1);
    Start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      checks++;
      if ({MemRD, MemAddr} !== {1'b1, 16'h0010}) begin
        errors++; $display("FAIL stride0 k=%0d got rd=%b addr=%h want 0010", k, MemRD, MemAddr);
      end
      @(negedge Clk1);
    end
    repeat (3) @(negedge Clk1);
    Stride = 16'd1;
  endtask
`endif

  initial begin
    logic [15:0] a;
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    for (int i = 0; i < 16; i++) mem[16'h0100 + i] = 16'h1111 * 16'(i);
    for (int i = 0; i < 16; i++) begin
      a = 16'hFFF8 + 16'(i);
      mem[a] = 16'h3000 + 16'(i);
    end
`ifdef STRIDE_EN
    Stride = 16'd1;
`endif
    test_reset();
    test_load();
    test_store();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
`ifdef STRIDE_EN
    test_stride();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
